// File: rtl/readbuf_line_ctrl.sv
// Line pointer / character counter for the read-buffer frame BRAM.
// Tracks committed lines with their lengths and steps the read address through them.
module readbuf_line_ctrl #(
    parameter int LINE_BITS = 3,
    parameter int CHAR_BITS = 11
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_newline,
    input  logic [CHAR_BITS-1:0]           wr_lastidx,
    output logic [LINE_BITS-1:0]           wr_line,
    output logic                           wr_full,
    input  logic                           rd_newline,
    input  logic                           rd_char_incr,
    output logic                           greenflag,
    output logic                           lastflag,
    output logic [LINE_BITS+CHAR_BITS-1:0] rd_addr,
    output logic [LINE_BITS:0]             lines_used,
    output logic                           overflow_err,
    output logic                           underflow_err
);

    localparam int NUM_LINES = 1 << LINE_BITS;
    localparam logic [LINE_BITS:0] FULL_COUNT = {1'b1, {LINE_BITS{1'b0}}};

    logic [LINE_BITS:0]     count_q, count_d;
    logic [LINE_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LINE_BITS-1:0]   rd_line_q, rd_line_d;
    logic [CHAR_BITS-1:0]   rd_char_q, rd_char_d;
    logic                   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;
    logic [CHAR_BITS-1:0]   len_q [NUM_LINES];
    logic [CHAR_BITS-1:0]   len_d [NUM_LINES];

    logic full, green, last, do_write, do_read;

    // Status is derived purely from registers so the read FSM never sees a combinational loop.
    always_comb begin
        full     = (count_q == FULL_COUNT);
        green    = (count_q != '0);
        last     = green && (rd_char_q == len_q[rd_line_q]);
        do_write = wr_newline && !full;
        do_read  = rd_newline && green;
    end

    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_line_d   = rd_line_q;
        rd_char_d   = rd_char_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        len_d       = len_q;

        if (do_write) begin
            len_d[wr_ptr_q] = wr_lastidx;
            wr_ptr_d        = wr_ptr_q + LINE_BITS'(1);
        end else if (wr_newline) begin
            overflow_d = 1'b1;
        end

        // Retiring a line takes priority over stepping within it.
        if (do_read) begin
            rd_line_d = rd_line_q + LINE_BITS'(1);
            rd_char_d = '0;
        end else if (rd_newline) begin
            underflow_d = 1'b1;
        end else if (rd_char_incr && green && !last) begin
            rd_char_d = rd_char_q + CHAR_BITS'(1);
        end

        case ({do_write, do_read})
            2'b10:   count_d = count_q + (LINE_BITS+1)'(1);
            2'b01:   count_d = count_q - (LINE_BITS+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_line_q   <= '0;
            rd_char_q   <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_line_q   <= rd_line_d;
            rd_char_q   <= rd_char_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Length table is left unreset: a line's entry is always written before it can be read.
    always_ff @(posedge clk) begin
        len_q <= len_d;
    end

    assign wr_line       = wr_ptr_q;
    assign wr_full       = full;
    assign greenflag     = green;
    assign lastflag      = last;
    assign rd_addr       = {rd_line_q, rd_char_q};
    assign lines_used    = count_q;
    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

endmodule

// File: tb/tb_readbuf_line_ctrl.sv
// Directed bench for readbuf_line_ctrl: vector table for single-cycle behaviour,
// then hand-written sequences for wrap-around reading and mid-line reset.
module tb_readbuf_line_ctrl;

    localparam int LB = 3;
    localparam int CB = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_newline;
    logic [CB-1:0] wr_lastidx;
    logic [LB-1:0] wr_line;
    logic          wr_full;
    logic          rd_newline;
    logic          rd_char_incr;
    logic          greenflag;
    logic          lastflag;
    logic [LB+CB-1:0] rd_addr;
    logic [LB:0]   lines_used;
    logic          overflow_err;
    logic          underflow_err;

    int checks = 0;
    int failures = 0;

    readbuf_line_ctrl #(.LINE_BITS(LB), .CHAR_BITS(CB)) dut (
        .clk(clk), .rst(rst),
        .wr_newline(wr_newline), .wr_lastidx(wr_lastidx),
        .wr_line(wr_line), .wr_full(wr_full),
        .rd_newline(rd_newline), .rd_char_incr(rd_char_incr),
        .greenflag(greenflag), .lastflag(lastflag),
        .rd_addr(rd_addr), .lines_used(lines_used),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rst;
        logic          wn;
        logic [CB-1:0] li;
        logic          rn;
        logic          incr;
    } in_t;

    typedef struct packed {
        logic [LB-1:0]    wr_line;
        logic             wr_full;
        logic             green;
        logic             last;
        logic [LB+CB-1:0] addr;
        logic [LB:0]      used;
        logic             ovf;
        logic             unf;
    } out_t;

    typedef struct {
        in_t   stim;
        out_t  exp;
        string name;
    } vec_t;

    vec_t vecs[$];

    function automatic in_t mk_in(input logic r, input logic wn, input int li,
                                  input logic rn, input logic incr);
        in_t s;
        s.rst  = r;
        s.wn   = wn;
        s.li   = CB'(li);
        s.rn   = rn;
        s.incr = incr;
        return s;
    endfunction

    function automatic out_t mk_out(input int wl, input logic full, input logic g,
                                    input logic l, input int line, input int ch,
                                    input int used, input logic ovf, input logic unf);
        out_t o;
        o.wr_line = LB'(wl);
        o.wr_full = full;
        o.green   = g;
        o.last    = l;
        o.addr    = {LB'(line), CB'(ch)};
        o.used    = (LB+1)'(used);
        o.ovf     = ovf;
        o.unf     = unf;
        return o;
    endfunction

    // Drive one cycle of inputs at the falling edge, then settle just after the rising edge.
    task automatic applyStimulus(input in_t s);
        @(negedge clk);
        rst          = s.rst;
        wr_newline   = s.wn;
        wr_lastidx   = s.li;
        rd_newline   = s.rn;
        rd_char_incr = s.incr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        out_t act;
        act = {wr_line, wr_full, greenflag, lastflag, rd_addr, lines_used,
               overflow_err, underflow_err};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got wl=%0d full=%0b g=%0b l=%0b addr=%0d:%0d used=%0d ovf=%0b unf=%0b, want wl=%0d full=%0b g=%0b l=%0b addr=%0d:%0d used=%0d ovf=%0b unf=%0b",
                     name, act.wr_line, act.wr_full, act.green, act.last,
                     act.addr[LB+CB-1:CB], act.addr[CB-1:0], act.used, act.ovf, act.unf,
                     exp.wr_line, exp.wr_full, exp.green, exp.last,
                     exp.addr[LB+CB-1:CB], exp.addr[CB-1:0], exp.used, exp.ovf, exp.unf);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic void add(input string n, input in_t s, input out_t o);
        vec_t v;
        v.stim = s;
        v.exp  = o;
        v.name = n;
        vecs.push_back(v);
    endfunction

    int lens[$];
    int model_rd;
    int model_wr;
    int steps;
    int li;

    initial begin
        rst = 1'b1; wr_newline = 1'b0; wr_lastidx = '0;
        rd_newline = 1'b0; rd_char_incr = 1'b0;

        // Single-line read with last-word hold, then retire.
        add("reset",        mk_in(1,0,0,0,0), mk_out(0,0,0,0,0,0,0,0,0));
        add("commit_li3",   mk_in(0,1,3,0,0), mk_out(1,0,1,0,0,0,1,0,0));
        add("incr1",        mk_in(0,0,0,0,1), mk_out(1,0,1,0,0,1,1,0,0));
        add("incr2",        mk_in(0,0,0,0,1), mk_out(1,0,1,0,0,2,1,0,0));
        add("incr3_last",   mk_in(0,0,0,0,1), mk_out(1,0,1,1,0,3,1,0,0));
        add("incr4_hold",   mk_in(0,0,0,0,1), mk_out(1,0,1,1,0,3,1,0,0));
        add("retire",       mk_in(0,0,0,1,0), mk_out(1,0,0,0,1,0,0,0,0));
        // Underflow from the reset state.
        add("reset2",       mk_in(1,0,0,0,0), mk_out(0,0,0,0,0,0,0,0,0));
        add("underflow",    mk_in(0,0,0,1,0), mk_out(0,0,0,0,0,0,0,0,1));
        add("incr_empty",   mk_in(0,0,0,0,1), mk_out(0,0,0,0,0,0,0,0,1));
        // Fill all eight lines, then overflow.
        add("reset3",       mk_in(1,0,0,0,0), mk_out(0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 8; i++)
            add($sformatf("fill%0d", i), mk_in(0,1,i,0,0),
                mk_out((i+1)%8, i==7, 1, 1, 0, 0, i+1, 0, 0));
        add("overflow",     mk_in(0,1,5,0,0), mk_out(0,1,1,1,0,0,8,1,0));
        add("full_wr_rd",   mk_in(0,1,5,1,0), mk_out(0,0,1,0,1,0,7,1,0));
        // Concurrent commit and retire with two lines held; incr loses to retire.
        add("reset4",       mk_in(1,0,0,0,0), mk_out(0,0,0,0,0,0,0,0,0));
        add("c2_a",         mk_in(0,1,4,0,0), mk_out(1,0,1,0,0,0,1,0,0));
        add("c2_b",         mk_in(0,1,6,0,0), mk_out(2,0,1,0,0,0,2,0,0));
        add("wr_rd_same",   mk_in(0,1,9,1,0), mk_out(3,0,1,0,1,0,2,0,0));
        add("incr_l1",      mk_in(0,0,0,0,1), mk_out(3,0,1,0,1,1,2,0,0));
        add("incr_and_rd",  mk_in(0,0,0,1,1), mk_out(3,0,1,0,2,0,1,0,0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].stim);
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        // Wrap-around: every line's length must be recovered from where lastflag rises.
        applyStimulus(mk_in(1,0,0,0,0));
        model_rd = 0;
        model_wr = 0;
        lens.delete();
        for (int k = 0; k < 22; k++) begin
            li = $urandom_range(0, 12);
            applyStimulus(mk_in(0,1,li,0,0));
            lens.push_back(li);
            model_wr++;
            if (k < 2) continue;
            checkOutput($sformatf("wrap_start%0d", k),
                        mk_out(model_wr%8, 0, 1, lens[0]==0, model_rd%8, 0,
                               lens.size(), 0, 0));
            steps = 0;
            while (!lastflag && steps < 40) begin
                applyStimulus(mk_in(0,0,0,0,1));
                steps++;
            end
            checkValue($sformatf("wrap_len%0d", k), steps, lens[0]);
            applyStimulus(mk_in(0,0,0,0,1));
            checkOutput($sformatf("wrap_hold%0d", k),
                        mk_out(model_wr%8, 0, 1, 1, model_rd%8, lens[0],
                               lens.size(), 0, 0));
            applyStimulus(mk_in(0,0,0,1,0));
            model_rd++;
            void'(lens.pop_front());
        end

        // Reset in the middle of a line discards everything.
        applyStimulus(mk_in(1,0,0,0,0));
        for (int i = 0; i < 3; i++) applyStimulus(mk_in(0,1,9,0,0));
        for (int i = 0; i < 5; i++) applyStimulus(mk_in(0,0,0,0,1));
        checkOutput("mid_line", mk_out(3,0,1,0,0,5,3,0,0));
        applyStimulus(mk_in(1,0,0,0,0));
        checkOutput("mid_reset", mk_out(0,0,0,0,0,0,0,0,0));
        applyStimulus(mk_in(0,1,2,0,0));
        checkOutput("post_w0", mk_out(1,0,1,0,0,0,1,0,0));
        applyStimulus(mk_in(0,0,0,0,1));
        checkOutput("post_w1", mk_out(1,0,1,0,0,1,1,0,0));
        applyStimulus(mk_in(0,0,0,0,1));
        checkOutput("post_w2", mk_out(1,0,1,1,0,2,1,0,0));
        applyStimulus(mk_in(0,0,0,1,0));
        checkOutput("post_retire", mk_out(1,0,0,0,1,0,0,0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/readbuf_line_ctrl.md
Name: readbuf_line_ctrl

Overview:
Line-pointer and character-counter controller (the "CountersBlock") for the frame buffer BRAM read by the read-buffer FSM. The BRAM is organised as 2^LINE_BITS lines of up to 2^CHAR_BITS words; each line holds one frame. The write side commits complete lines with their length. The block tracks occupancy, drives the BRAM read address, and gives the read FSM greenflag (a line is ready) and lastflag (current word is the last of the line).

Parameters:
LINE_BITS, 3, log2 of number of lines (8 lines)
CHAR_BITS, 11, log2 of max words per line (2048)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
wr_newline  input  1  pulse: writer has finished line wr_line
wr_lastidx  input  CHAR_BITS  index of last word of committed line (length-1); sampled with wr_newline
wr_line  output  LINE_BITS  line the writer must fill next (write pointer)
wr_full  output  1  all lines occupied
rd_newline  input  1  pulse from read FSM: current line consumed
rd_char_incr  input  1  pulse from read FSM: advance to next word
greenflag  output  1  at least one committed line unread
lastflag  output  1  read address points at last word of current line
rd_addr  output  LINE_BITS+CHAR_BITS  BRAM read address {rd_line, rd_char}
lines_used  output  LINE_BITS+1  occupied line count, 0..2^LINE_BITS
overflow_err  output  1  sticky: wr_newline while full
underflow_err  output  1  sticky: rd_newline while empty

Behaviour:
- Reset (sync, rst=1 at clock edge): wr_ptr=0, rd_line=0, rd_char=0, count=0, both error flags 0. The length table is not reset. After reset: wr_line=0, wr_full=0, greenflag=0, lastflag=0, rd_addr=0, lines_used=0. Reset mid-frame discards all lines.
- State:
  - count register, LINE_BITS+1 bits.
  - wr_ptr and rd_line, LINE_BITS bits each; wrap naturally modulo 2^LINE_BITS.
  - rd_char, CHAR_BITS bits.
  - len table, 2^LINE_BITS x CHAR_BITS registers.
- Combinational outputs from registers only, no input-to-output paths:
  - wr_full = (count == 2^LINE_BITS)
  - greenflag = (count != 0)
  - lastflag = greenflag & (rd_char == len[rd_line])
  - rd_addr = {rd_line, rd_char}
  - wr_line = wr_ptr; lines_used = count
- Write commit: wr_newline & ~wr_full -> len[wr_ptr] <= wr_lastidx; wr_ptr <= wr_ptr+1; count+1. greenflag rises the cycle after commit.
  - wr_newline & wr_full -> dropped: no pointer, table or count change; overflow_err <= 1.
- Read retire: rd_newline & greenflag -> rd_line <= rd_line+1; rd_char <= 0; count-1.
  - rd_newline & ~greenflag -> ignored; underflow_err <= 1.
- rd_char_incr (without rd_newline):
  - greenflag & ~lastflag -> rd_char+1.
  - At lastflag -> holds; no wrap into the next line.
  - ~greenflag -> ignored.
- rd_char_incr & rd_newline in the same cycle: rd_newline wins; rd_char <= 0.
- Simultaneous valid commit and retire: count unchanged; both pointers advance.
  - When full, a retire in the same cycle does not make room for a concurrent wr_newline; wr_full is evaluated from the registered count, so that write is dropped.
- Latency:
  - rd_addr changes the cycle after rd_char_incr or rd_newline.
  - BRAM data follows one cycle later. The read FSM's one-cycle tvalid/tlast delay covers this; no extra registering here.
- Single-word line (wr_lastidx=0): lastflag=1 as soon as greenflag=1.
- Error flags clear only on rst.

Test Plan:
1. Reset -> wr_line=0, wr_full=0, greenflag=0, lastflag=0, rd_addr=0, lines_used=0, errors 0. Then commit one line with wr_lastidx=3 -> next cycle greenflag=1, lines_used=1. Pulse rd_char_incr 3 times -> rd_addr 0,1,2,3; lastflag=1 only at 3. Fourth incr -> rd_addr stays 3. rd_newline -> greenflag=0, rd_addr={1,0}.
2. Commit 8 lines (lastidx 0..7) -> wr_full=1, lines_used=8, wr_line=0. 9th wr_newline -> overflow_err=1, lines_used=8, len table unchanged (line 0 still lastidx 0, lastflag=1 immediately).
3. rd_newline at reset state -> underflow_err=1, rd_addr=0, lines_used=0.
4. With lines_used=2, assert wr_newline and rd_newline together -> lines_used=2, rd_line+1, wr_ptr+1. At lines_used=8 repeat -> write dropped, overflow_err=1, lines_used=7.
5. Run 20 commit/retire cycles of random lengths -> pointers wrap 7->0. Every line reads back its own lastidx via lastflag position; rd_char always 0 at line start.
6. rst asserted mid-line (rd_char=5, lines_used=3) -> next cycle all outputs at reset values. Subsequent commit with lastidx=2 -> correct 3-word read.
